// File: rtl/mux_tree_pipe.sv
// mux_tree_pipe: pipelined NUM_IN:1 mux built from registered levels of 4:1 nodes.
// A single global advance (adv) moves every stage at once, so bubbles are kept
// and ordering is preserved. Optional macro: MUX_ERR_EN adds the out_err flag,
// which marks items whose select was >= NUM_IN.

// One 4:1 tree node; d packs its four inputs, input i at [i*WIDTH +: WIDTH].
module mux4_node #(
   parameter int WIDTH = 8
) (
   input  logic [4*WIDTH-1:0] d,
   input  logic [1:0]         sel,
   output logic [WIDTH-1:0]   y
);
   // pick one of four inputs
   always_comb begin
      y = d[WIDTH-1:0];
      case (sel)
         2'd0: y = d[0*WIDTH +: WIDTH];
         2'd1: y = d[1*WIDTH +: WIDTH];
         2'd2: y = d[2*WIDTH +: WIDTH];
         2'd3: y = d[3*WIDTH +: WIDTH];
         default: y = d[WIDTH-1:0];
      endcase
   end
endmodule

module mux_tree_pipe #(
   parameter  int WIDTH  = 8,
   parameter  int NUM_IN = 16,
   localparam int LEVELS = (NUM_IN <= 4) ? 1 : (NUM_IN <= 16) ? 2 : (NUM_IN <= 64) ? 3 : 4,
   localparam int SEL_W  = 2*LEVELS
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   input  logic                    out_ready
`ifdef MUX_ERR_EN
   ,
   output logic                    out_err
`endif
);
   // leaf count rounded up to a full 4-ary tree
   localparam int PAD = 1 << (2*LEVELS);

   logic                   adv;
   logic [LEVELS-1:0]      vld_pipe;
   logic [PAD*WIDTH-1:0]   leaves;

   assign out_valid = vld_pipe[LEVELS-1];
   assign adv       = ~out_valid | out_ready;
   assign in_ready  = adv;

   // pad missing channels with zero so out-of-range selects read 0
   always_comb begin
      leaves = '0;
      leaves[NUM_IN*WIDTH-1:0] = in_data;
   end

   // valid bits shift with the data; in_valid=0 enters as a bubble
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   vld_pipe <= '0;
      else if (adv) vld_pipe <= (vld_pipe << 1) | LEVELS'(in_valid);
   end

   for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
      localparam int NODES = PAD >> (2*(l+1));
      localparam int SW    = SEL_W - 2*l;   // select bits still unconsumed here

      logic [4*NODES*WIDTH-1:0] din;
      logic [SW-1:0]            sin;
      logic [NODES*WIDTH-1:0]   mout;
      logic [NODES*WIDTH-1:0]   q;

      if (l == 0) begin : g_src
         assign din = leaves;
         assign sin = in_sel;
      end else begin : g_src
         assign din = g_lvl[l-1].q;
         assign sin = g_lvl[l-1].g_sreg.sq;
      end

      for (genvar n = 0; n < NODES; n++) begin : g_node
         mux4_node #(.WIDTH(WIDTH)) u_node (
            .d   (din[n*4*WIDTH +: 4*WIDTH]),
            .sel (sin[1:0]),
            .y   (mout[n*WIDTH +: WIDTH])
         );
      end

      // level output register
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)   q <= '0;
         else if (adv) q <= mout;
      end

      // carry the higher select bits forward for the remaining levels
      if (l < LEVELS-1) begin : g_sreg
         logic [SW-3:0] sq;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)   sq <= '0;
            else if (adv) sq <= sin[SW-1:2];
         end
      end
   end

   assign out_data = g_lvl[LEVELS-1].q;

`ifdef MUX_ERR_EN
   logic [LEVELS-1:0] err_pipe;
   logic              oor;

   // one extra bit of headroom so NUM_IN=256 compares correctly
   assign oor = {1'b0, in_sel} >= (SEL_W+1)'(NUM_IN);

   // error flag travels with its item; bubbles carry 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   err_pipe <= '0;
      else if (adv) err_pipe <= (err_pipe << 1) | LEVELS'(in_valid & oor);
   end

   assign out_err = err_pipe[LEVELS-1];
`else
   // no error tracking: out-of-range selects just read the zero padding
`endif
endmodule

// File: tb/tb_mux_tree_pipe.sv
// Bench for mux_tree_pipe: three sizes (16, 10 and 2 channels) share one stimulus
// stream; a per-instance expectation FIFO holds the value the selected channel had
// when the item was accepted.
module tb_mux_tree_pipe;
   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic [127:0] chan = '0;
   logic [7:0]   sel = '0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;

   logic         ir0, ir1, ir2, ov0, ov1, ov2;
   logic [7:0]   od0, od1, od2;
`ifdef MUX_ERR_EN
   logic         oe0, oe1, oe2;
`endif

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;
   logic lat_chk = 1'b0;

   logic [7:0] exp_d [3][256];
   logic       exp_e [3][256];
   int         exp_c [3][256];
   int         wr [3];
   int         rd [3];
   logic       acc [3];

   always #5 clk = ~clk;

   mux_tree_pipe #(.WIDTH(8), .NUM_IN(16)) u16 (
      .clk(clk), .rst_n(rst_n), .in_data(chan), .in_sel(sel[3:0]), .in_valid(in_valid),
      .in_ready(ir0), .out_data(od0), .out_valid(ov0), .out_ready(out_ready)
`ifdef MUX_ERR_EN
      , .out_err(oe0)
`endif
   );
   mux_tree_pipe #(.WIDTH(8), .NUM_IN(10)) u10 (
      .clk(clk), .rst_n(rst_n), .in_data(chan[79:0]), .in_sel(sel[3:0]), .in_valid(in_valid),
      .in_ready(ir1), .out_data(od1), .out_valid(ov1), .out_ready(out_ready)
`ifdef MUX_ERR_EN
      , .out_err(oe1)
`endif
   );
   mux_tree_pipe #(.WIDTH(8), .NUM_IN(2)) u2 (
      .clk(clk), .rst_n(rst_n), .in_data(chan[15:0]), .in_sel(sel[1:0]), .in_valid(in_valid),
      .in_ready(ir2), .out_data(od2), .out_valid(ov2), .out_ready(out_ready)
`ifdef MUX_ERR_EN
      , .out_err(oe2)
`endif
   );

   function automatic int ni(input int d);   return (d == 0) ? 16 : (d == 1) ? 10 : 2; endfunction
   function automatic int lev(input int d);  return (d == 2) ? 1 : 2;                  endfunction
   function automatic int smask(input int d); return (d == 2) ? 3 : 15;                endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // compare outputs against the expectation FIFOs and record this cycle's handshakes
   task automatic sb_eval();
      for (int d = 0; d < 3; d++) begin
         logic v, r, e;
         logic [7:0] o;
         int s;
         v = (d == 0) ? ov0 : (d == 1) ? ov1 : ov2;
         r = (d == 0) ? ir0 : (d == 1) ? ir1 : ir2;
         o = (d == 0) ? od0 : (d == 1) ? od1 : od2;
`ifdef MUX_ERR_EN
         e = (d == 0) ? oe0 : (d == 1) ? oe1 : oe2;
`else
         e = 1'b0;
`endif
         acc[d] = 1'b0;
         if (v) begin
            if (wr[d] == rd[d]) begin
               chk($sformatf("spurious_valid_d%0d", d), 32'(v), 32'd0);
            end else begin
               chk($sformatf("data_d%0d", d), 32'(o), 32'(exp_d[d][rd[d] % 256]));
`ifdef MUX_ERR_EN
               chk($sformatf("err_d%0d", d), 32'(e), 32'(exp_e[d][rd[d] % 256]));
`endif
               if (out_ready) begin
                  if (lat_chk)
                     chk($sformatf("latency_d%0d", d), 32'(cyc - exp_c[d][rd[d] % 256]), 32'(lev(d)));
                  rd[d]++;
               end
            end
         end else begin
`ifdef MUX_ERR_EN
            chk($sformatf("err_idle_d%0d", d), 32'(e), 32'd0);
`endif
         end
         if (in_valid && r) begin
            s = int'(sel) & smask(d);
            exp_d[d][wr[d] % 256] = (s < ni(d)) ? chan[s*8 +: 8] : 8'h00;
            exp_e[d][wr[d] % 256] = (s >= ni(d));
            exp_c[d][wr[d] % 256] = cyc;
            wr[d]++;
            acc[d] = 1'b1;
         end
      end
   endtask

   // inputs are set at a falling edge; settle, score, then move to the next falling edge
   task automatic cycle();
      #1;
      sb_eval();
      @(negedge clk);
      cyc++;
   endtask

   task automatic set_ramp();
      for (int k = 0; k < 16; k++) chan[k*8 +: 8] = 8'h10 + 8'(k);
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin wr[d] = 0; rd[d] = 0; acc[d] = 1'b0; end

      // reset state
      #2 rst_n = 1'b0;
      #1;
      chk("reset_valid16", 32'(ov0), 0);
      chk("reset_data16", 32'(od0), 0);
      chk("reset_valid2", 32'(ov2), 0);
`ifdef MUX_ERR_EN
      chk("reset_err10", 32'(oe1), 0);
`endif
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // sweep all 16 selects back to back
      set_ramp();
      out_ready = 1'b1;
      lat_chk = 1'b1;
      for (int k = 0; k < 16; k++) begin
         in_valid = 1'b1;
         sel = 8'(k);
         cycle();
         chk("sweep_in_ready", 32'(ir0), 1);
      end
      in_valid = 1'b0;
      repeat (3) cycle();

      // backpressure: 3,5,7 with the output held for 4 cycles
      lat_chk = 1'b0;
      out_ready = 1'b0;
      in_valid = 1'b1;
      sel = 8'd3;
      cycle();
      sel = 8'd5;
      cycle();
      chk("bp_valid", 32'(ov0), 1);
      sel = 8'd7;
      repeat (4) begin
         cycle();
         chk("bp_hold_data", 32'(od0), 32'h13);
         chk("bp_in_ready", 32'(ir0), 0);
      end
      out_ready = 1'b1;
      acc[0] = 1'b0;
      for (int k = 0; k < 10 && !acc[0]; k++) cycle();
      chk("bp_accept_7", 32'(acc[0]), 1);
      in_valid = 1'b0;
      repeat (4) cycle();

      // out of range on the 10-channel instance, then its last legal channel
      lat_chk = 1'b1;
      in_valid = 1'b1;
      sel = 8'd12;
      cycle();
      sel = 8'd9;
      cycle();
      chk("oor_valid", 32'(ov1), 1);
      chk("oor_data", 32'(od1), 0);
`ifdef MUX_ERR_EN
      chk("oor_err", 32'(oe1), 1);
`endif
      in_valid = 1'b0;
      cycle();
      chk("ch9_data", 32'(od1), 32'h19);
`ifdef MUX_ERR_EN
      chk("ch9_err", 32'(oe1), 0);
`endif
      repeat (2) cycle();

      // 2-channel instance: single-cycle latency
      in_valid = 1'b1;
      sel = 8'd1;
      cycle();
      in_valid = 1'b0;
      chk("min_valid", 32'(ov2), 1);
      chk("min_data", 32'(od2), 32'h11);
      repeat (3) cycle();

      // capture: channel 4 changes right after acceptance
      in_valid = 1'b1;
      sel = 8'd4;
      cycle();
      in_valid = 1'b0;
      chan[39:32] = 8'hA5;
      cycle();
      chk("capture_data", 32'(od0), 32'h14);
      repeat (3) cycle();
      set_ramp();

      // reset with two items in flight
      lat_chk = 1'b0;
      out_ready = 1'b0;
      in_valid = 1'b1;
      sel = 8'd2;
      cycle();
      sel = 8'd6;
      cycle();
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_valid16", 32'(ov0), 0);
      chk("midrst_data16", 32'(od0), 0);
      chk("midrst_valid10", 32'(ov1), 0);
      for (int d = 0; d < 3; d++) rd[d] = wr[d];
      @(negedge clk);
      cycle();
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (5) cycle();
      chk("postrst_quiet", 32'(ov0 | ov1 | ov2), 0);

      // randomized traffic with random backpressure
      for (int k = 0; k < 400; k++) begin
         chan = {$urandom, $urandom, $urandom, $urandom};
         sel = 8'($urandom);
         in_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (5) cycle();
      for (int d = 0; d < 3; d++)
         chk($sformatf("drained_d%0d", d), 32'(wr[d] - rd[d]), 0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule
